// File: rtl/dma_arb_pkg.sv
// rtl/dma_arb_pkg.sv - shared state encoding, default widths and index-width helper for the DMA port arbiter
package dma_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_DATA_W = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_port_arbiter_if.sv
// rtl/dma_port_arbiter_if.sv - requester-side and downstream DMA port signals; err_timeout exists only with DMA_ARB_TIMEOUT_EN
interface dma_port_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = dma_arb_pkg::DMA_ADDR_W,
    parameter int DATA_W = dma_arb_pkg::DMA_DATA_W
);
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_read;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*DATA_W-1:0] req_writedata;
    logic [DATA_W-1:0]       req_readdata;
    logic [N_REQ-1:0]        req_rdy;
    logic [ADDR_W-1:0]       dma_addr;
    logic                    dma_read;
    logic                    dma_write;
    logic [DATA_W-1:0]       dma_writedata;
    logic [DATA_W-1:0]       dma_readdata;
    logic                    dma_rdy;
    logic                    err_overrun;
    logic                    busy;
`ifdef DMA_ARB_TIMEOUT_EN
    logic                    err_timeout;
`endif

    // master: the arbiter, which owns the downstream DMA port
    modport master (
`ifdef DMA_ARB_TIMEOUT_EN
        output err_timeout,
`endif
        input  req_addr, req_read, req_write, req_writedata, dma_readdata, dma_rdy,
        output req_readdata, req_rdy, dma_addr, dma_read, dma_write, dma_writedata,
        output err_overrun, busy
    );

    modport slave (
`ifdef DMA_ARB_TIMEOUT_EN
        input  err_timeout,
`endif
        output req_addr, req_read, req_write, req_writedata, dma_readdata, dma_rdy,
        input  req_readdata, req_rdy, dma_addr, dma_read, dma_write, dma_writedata,
        input  err_overrun, busy
    );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority encoder: first pending index at or after rr_ptr
module rr_picker
    import dma_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    int idx;

    // Scan from the farthest offset down so the nearest pending index wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (pending[idx]) begin
                grant = IDX_W'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_port_arbiter.sv
// rtl/dma_port_arbiter.sv - round-robin sharing of one DMA master port among single-strobe requesters; DMA_ARB_TIMEOUT_EN adds a WAIT watchdog
module dma_port_arbiter
    import dma_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W
`ifdef DMA_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input logic              clk,
    input logic              rst,
    dma_port_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_t        state;
    logic [N_REQ-1:0]  pending;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  next_ptr;
    logic              any;
    logic              complete;
    logic [ADDR_W-1:0] buf_addr [N_REQ];
    logic [DATA_W-1:0] buf_data [N_REQ];
    logic [N_REQ-1:0]  buf_wr;
    logic [ADDR_W-1:0] dma_addr_q;
    logic [DATA_W-1:0] dma_data_q;
    logic              dma_read_q;
    logic              dma_write_q;
    logic              err_overrun_q;

    rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .grant   (pick),
        .any     (any)
    );

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    logic [TMR_W-1:0] timer;
    logic             timed_out;
    logic             err_timeout_q;

    // Fires on the TIMEOUT-th WAIT cycle; a real dma_rdy in that cycle still wins.
    assign timed_out       = (state == ARB_WAIT) && !bus.dma_rdy && (timer == TMR_W'(TIMEOUT - 1));
    assign complete        = (state == ARB_WAIT) && (bus.dma_rdy || timed_out);
    assign bus.err_timeout = err_timeout_q;
`else
    assign complete = (state == ARB_WAIT) && bus.dma_rdy;
`endif

    assign next_ptr          = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + IDX_W'(1);
    assign bus.dma_addr      = dma_addr_q;
    assign bus.dma_writedata = dma_data_q;
    assign bus.dma_read      = dma_read_q;
    assign bus.dma_write     = dma_write_q;
    assign bus.err_overrun   = err_overrun_q;
    assign bus.busy          = (state != ARB_IDLE) || (|pending);

    always_comb begin
        bus.req_rdy      = '0;
        bus.req_readdata = '0;
        if (complete) begin
            bus.req_rdy[grant] = 1'b1;
            if (bus.dma_rdy) begin
                bus.req_readdata = bus.dma_readdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            pending       <= '0;
            rr_ptr        <= '0;
            grant         <= '0;
            buf_wr        <= '0;
            dma_addr_q    <= '0;
            dma_data_q    <= '0;
            dma_read_q    <= 1'b0;
            dma_write_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                buf_addr[i] <= '0;
                buf_data[i] <= '0;
            end
`ifdef DMA_ARB_TIMEOUT_EN
            timer         <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            // A strobe landing on its own completion cycle is a fresh command, not an overrun.
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_read[i] || bus.req_write[i]) begin
                    if (pending[i] && !(complete && grant == IDX_W'(i))) begin
                        err_overrun_q <= 1'b1;
                    end else begin
                        pending[i]  <= 1'b1;
                        buf_addr[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
                        buf_data[i] <= bus.req_writedata[i*DATA_W +: DATA_W];
                        buf_wr[i]   <= bus.req_write[i];
                    end
                end else if (complete && grant == IDX_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end

            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        grant       <= pick;
                        dma_addr_q  <= buf_addr[pick];
                        dma_data_q  <= buf_data[pick];
                        dma_read_q  <= !buf_wr[pick];
                        dma_write_q <= buf_wr[pick];
                        state       <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    dma_addr_q  <= '0;
                    dma_data_q  <= '0;
                    dma_read_q  <= 1'b0;
                    dma_write_q <= 1'b0;
                    state       <= ARB_WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
                    timer       <= '0;
`endif
                end
                ARB_WAIT: begin
                    if (complete) begin
                        rr_ptr <= next_ptr;
                        state  <= ARB_IDLE;
`ifdef DMA_ARB_TIMEOUT_EN
                        if (timed_out) begin
                            err_timeout_q <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
`endif
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
